// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt/eret sequencer between M stage and CP0 (optional event counter: EXC_CTRL_CNT_EN)
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exc_code,
    input  logic        m_eret,
    input  logic [31:0] next_pc,
    input  logic        cp0_req,
    input  logic [31:0] cp0_epc,
    output logic [31:0] cp0_vpc,
    output logic        cp0_bd,
    output logic [4:0]  cp0_exc_code,
    output logic        exl_clr,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        int_ack,
    output logic        busy,
    output logic [31:0] exc_cnt
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_RET} state_t;

    // Counter reload value; zero means the window ends with the accept cycle itself.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       in_run;
    logic       acc_eret;
    logic       acc_req;

    // Accept decision and accept-cycle outputs are combinational so CP0 commits on the same edge.
    always_comb begin
        cp0_vpc      = m_valid ? m_pc : next_pc;
        cp0_bd       = m_valid & m_bd;
        cp0_exc_code = m_valid ? m_exc_code : 5'd0;
        in_run       = (state == S_RUN);
        acc_eret     = in_run & m_valid & m_eret;
        acc_req      = in_run & ~acc_eret & cp0_req;
        exl_clr      = acc_eret;
        pc_redirect  = acc_eret | acc_req;
        pc_target    = acc_eret ? cp0_epc : (acc_req ? HANDLER_ADDR : 32'h0);
        flush        = pc_redirect | ~in_run;
        int_ack      = acc_req & (cp0_exc_code == 5'd0);
        busy         = ~in_run;
    end

    // Sequencer: hold the flush window for FLUSH_CYCLES total cycles after each accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (acc_eret | acc_req) begin
                        cnt <= CNT_LOAD;
                        if (CNT_LOAD != 4'd0)
                            state <= acc_eret ? S_RET : S_FLUSH;
                    end
                end
                default: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= S_RUN;
                        cnt   <= 4'd0;
                    end
                end
            endcase
        end
    end

`ifdef EXC_CTRL_CNT_EN
    logic [31:0] exc_cnt_q;

    // Count accepted CP0 requests; eret is not an event. Wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            exc_cnt_q <= 32'h0;
        else if (acc_req)
            exc_cnt_q <= exc_cnt_q + 32'd1;
    end

    assign exc_cnt = exc_cnt_q;
`else
    assign exc_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exc_code;
    logic        m_eret;
    logic [31:0] next_pc;
    logic        cp0_req;
    logic [31:0] cp0_epc;

    logic [31:0] vpc1, tgt1, cnt1;
    logic        bd1, exl1, fl1, red1, ack1, busy1;
    logic [4:0]  code1;

    logic [31:0] vpc3, tgt3, cnt3;
    logic        bd3, exl3, fl3, red3, ack3, busy3;
    logic [4:0]  code3;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef EXC_CTRL_CNT_EN
    localparam logic [31:0] CNT4 = 32'd4;
    localparam logic [31:0] CNT2 = 32'd2;
`else
    localparam logic [31:0] CNT4 = 32'd0;
    localparam logic [31:0] CNT2 = 32'd0;
`endif

    exc_ctrl #(.HANDLER_ADDR(32'h0000_4180), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
        .m_exc_code(m_exc_code), .m_eret(m_eret), .next_pc(next_pc),
        .cp0_req(cp0_req), .cp0_epc(cp0_epc), .cp0_vpc(vpc1), .cp0_bd(bd1),
        .cp0_exc_code(code1), .exl_clr(exl1), .flush(fl1), .pc_redirect(red1),
        .pc_target(tgt1), .int_ack(ack1), .busy(busy1), .exc_cnt(cnt1)
    );

    exc_ctrl #(.HANDLER_ADDR(32'h0000_4180), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
        .m_exc_code(m_exc_code), .m_eret(m_eret), .next_pc(next_pc),
        .cp0_req(cp0_req), .cp0_epc(cp0_epc), .cp0_vpc(vpc3), .cp0_bd(bd3),
        .cp0_exc_code(code3), .exl_clr(exl3), .flush(fl3), .pc_redirect(red3),
        .pc_target(tgt3), .int_ack(ack3), .busy(busy3), .exc_cnt(cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; m_valid = 1'b0; m_pc = 32'h0; m_bd = 1'b0; m_exc_code = 5'd0;
        m_eret = 1'b0; next_pc = 32'h0; cp0_req = 1'b0; cp0_epc = 32'h0;
        step();
        step();
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_cnt", cnt1, 32'd0);
        reset = 1'b0;

        // idle
        m_valid = 1'b1; m_pc = 32'h3000;
        #1;
        check("idle_flush", {31'd0, fl1}, 32'd0);
        check("idle_redir", {31'd0, red1}, 32'd0);
        check("idle_exl", {31'd0, exl1}, 32'd0);
        check("idle_ack", {31'd0, ack1}, 32'd0);
        check("idle_tgt", tgt1, 32'h0);
        check("idle_vpc", vpc1, 32'h3000);
        check("idle_busy", {31'd0, busy1}, 32'd0);
        step();

        // exception in delay slot
        cp0_req = 1'b1; m_exc_code = 5'd10; m_pc = 32'h3010; m_bd = 1'b1;
        #1;
        check("exc_flush", {31'd0, fl1}, 32'd1);
        check("exc_redir", {31'd0, red1}, 32'd1);
        check("exc_tgt", tgt1, 32'h4180);
        check("exc_bd", {31'd0, bd1}, 32'd1);
        check("exc_code", {27'd0, code1}, 32'd10);
        check("exc_ack", {31'd0, ack1}, 32'd0);
        check("exc_vpc", vpc1, 32'h3010);
        step();
        cp0_req = 1'b0; m_bd = 1'b0;
        #1;
        check("exc_next_busy", {31'd0, busy1}, 32'd0);
        check("exc_next_flush", {31'd0, fl1}, 32'd0);
        step();

        // interrupt on a bubble
        m_valid = 1'b0; next_pc = 32'h3024; cp0_req = 1'b1; m_bd = 1'b1;
        #1;
        check("bub_vpc", vpc1, 32'h3024);
        check("bub_bd", {31'd0, bd1}, 32'd0);
        check("bub_code", {27'd0, code1}, 32'd0);
        check("bub_ack", {31'd0, ack1}, 32'd1);
        step();
        m_bd = 1'b0; cp0_req = 1'b0; m_exc_code = 5'd0;
        step();

        // eret wins over simultaneous req; req accepted right after
        m_valid = 1'b1; m_pc = 32'h3030; m_eret = 1'b1; cp0_req = 1'b1; cp0_epc = 32'h3040;
        #1;
        check("eret_exl", {31'd0, exl1}, 32'd1);
        check("eret_tgt", tgt1, 32'h3040);
        check("eret_ack", {31'd0, ack1}, 32'd0);
        check("eret_flush", {31'd0, fl1}, 32'd1);
        step();
        m_eret = 1'b0; m_pc = 32'h3040;
        #1;
        check("post_eret_redir", {31'd0, red1}, 32'd1);
        check("post_eret_tgt", tgt1, 32'h4180);
        check("post_eret_exl", {31'd0, exl1}, 32'd0);
        check("post_eret_ack", {31'd0, ack1}, 32'd1);
        step();
        cp0_req = 1'b0;
        step();

        // second eret, then fourth request
        m_eret = 1'b1; cp0_epc = 32'h3050;
        #1;
        check("eret2_tgt", tgt1, 32'h3050);
        step();
        m_eret = 1'b0; cp0_req = 1'b1; m_exc_code = 5'd3;
        #1;
        check("req4_ack", {31'd0, ack1}, 32'd0);
        step();
        cp0_req = 1'b0; m_exc_code = 5'd0;
        #1;
        check("exc_cnt4", cnt1, CNT4);
        step();

        // FLUSH_CYCLES=3 with request held for 5 cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_valid = 1'b1; m_pc = 32'h3100; cp0_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("f3_flush_%0d", i), {31'd0, fl3}, 32'd1);
            check($sformatf("f3_redir_%0d", i), {31'd0, red3}, (i == 0 || i == 3) ? 32'd1 : 32'd0);
            check($sformatf("f3_busy_%0d", i), {31'd0, busy3}, (i == 1 || i == 2 || i == 4) ? 32'd1 : 32'd0);
            step();
        end

        // reset in the middle of a flush window
        cp0_req = 1'b0;
        #1;
        check("f3_busy_mid", {31'd0, busy3}, 32'd1);
        check("f3_cnt_mid", cnt3, CNT2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("f3_rst_busy", {31'd0, busy3}, 32'd0);
        check("f3_rst_flush", {31'd0, fl3}, 32'd0);
        check("f3_rst_cnt", cnt3, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
